code_entry_fsm: RTL

Combination-lock controller that consumes the single-cycle press pulses produced by the per-button debouncers. It collects a fixed-length sequence of button presses, compares it against a stored code, and drives unlock, error and lockout indications. While unlocked, it can also capture a new code. It sits directly downstream of the debouncer bank and upstream of the display/LED logic.

---
 rtl/lock_pkg.sv | 33 +++
 rtl/cycle_timer.sv | 28 ++
 rtl/code_entry_fsm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock controller:
// state encoding, digit width and the power-up code.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5,
        PROGRAM = 3'd6
    } state_t;

    localparam int DIGIT_W  = 2;
    localparam int NUM_BTNS = 4;

    // Digit k sits at bits [2k+1:2k]; pattern 0,1,2,3 repeating for up to 7 digits.
    localparam logic [13:0] DEFAULT_CODE = 14'b10_01_00_11_10_01_00;

    // Lowest set button wins; only meaningful when exactly one bit is set.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [NUM_BTNS-1:0] b);
        digit_of = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (b[i]) digit_of = DIGIT_W'(i);
        end
    endfunction

    function automatic logic is_multi(input logic [NUM_BTNS-1:0] b);
        return (b != '0) && ((b & (b - NUM_BTNS'(1))) != '0);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire is high during the cycle the count reads 1.
// Holds at zero once drained.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/code_entry_fsm.sv
// Combination-lock controller: collects debounced press pulses, checks them
// against the stored code, and handles lockout and code programming.
module code_entry_fsm
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] btn_pulse,
    input  logic       set_mode,
    output logic       unlocked,
    output logic       error_pulse,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [2:0] state_o
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LK_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_digit_count;
    logic [CODE_W-1:0]   r_entry;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_entry_next;
    logic                r_bad;
    logic [FAIL_W-1:0]   r_fail_count;
    logic [FAIL_W-1:0]   w_fail_next;

    logic                w_press;
    logic                w_multi;
    logic [DIGIT_W-1:0]  w_digit;
    logic                w_last;
    logic                w_timeout;
    logic                w_lock_done;

    logic                w_capture;
    logic                w_start;
    logic                w_code_we;
    logic                w_fail_inc;
    logic                w_fail_clr;
    logic                w_lock_load;

    assign w_press     = |btn_pulse;
    assign w_multi     = is_multi(btn_pulse);
    assign w_digit     = digit_of(btn_pulse);
    assign w_last      = (r_digit_count == 3'(CODE_LEN - 1));
    assign w_fail_next = r_fail_count + FAIL_W'(1);

    always_comb begin
        w_entry_next = r_entry;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (r_digit_count == 3'(k)) w_entry_next[k*DIGIT_W +: DIGIT_W] = w_digit;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_start     = 1'b0;
        w_code_we   = 1'b0;
        w_fail_inc  = 1'b0;
        w_fail_clr  = 1'b0;
        w_lock_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_capture = 1'b1;
                    w_start   = 1'b1;
                    w_next    = w_last ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // A press on the expiry cycle takes priority over the timeout.
                if (w_press) begin
                    w_capture = 1'b1;
                    if (w_last) w_next = CHECK;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            CHECK: begin
                if (r_entry == r_code && !r_bad) begin
                    w_next     = OPEN;
                    w_fail_clr = 1'b1;
                end else begin
                    w_next = FAIL;
                end
            end
            FAIL: begin
                w_fail_inc = 1'b1;
                if (w_fail_next == FAIL_W'(MAX_FAILS)) begin
                    w_next      = LOCKOUT;
                    w_lock_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            LOCKOUT: begin
                if (w_lock_done) begin
                    w_next     = IDLE;
                    w_fail_clr = 1'b1;
                end
            end
            OPEN: begin
                if (w_press && set_mode) begin
                    w_capture = 1'b1;
                    w_start   = 1'b1;
                    if (w_last) begin
                        w_code_we = !w_multi;
                        w_next    = IDLE;
                    end else begin
                        w_next = PROGRAM;
                    end
                end else if (w_press) begin
                    w_next = IDLE;
                end
            end
            PROGRAM: begin
                if (w_press) begin
                    w_capture = 1'b1;
                    if (w_last) begin
                        w_code_we = !(r_bad || w_multi);
                        w_next    = IDLE;
                    end
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: the code register is reset explicitly because a reset must restore the default code.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_digit_count <= '0;
            r_entry       <= '0;
            r_bad         <= 1'b0;
            r_code        <= DEFAULT_CODE[CODE_W-1:0];
            r_fail_count  <= '0;
        end else begin
            if (w_next inside {IDLE, OPEN, CHECK, LOCKOUT}) r_digit_count <= '0;
            else if (w_capture)                            r_digit_count <= r_digit_count + 3'd1;

            if (w_capture) begin
                r_entry <= w_entry_next;
                r_bad   <= w_multi | (r_bad & !w_start);
            end

            if (w_code_we) r_code <= w_entry_next;

            if (w_fail_clr)      r_fail_count <= '0;
            else if (w_fail_inc) r_fail_count <= w_fail_next;
        end
    end

    cycle_timer #(.WIDTH(TO_W)) u_press_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_capture),
        .load_val (TO_W'(TIMEOUT_CYCLES)),
        .expire   (w_timeout)
    );

    cycle_timer #(.WIDTH(LK_W)) u_lockout_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_lock_load),
        .load_val (LK_W'(LOCKOUT_CYCLES)),
        .expire   (w_lock_done)
    );

    assign unlocked    = (r_state == OPEN);
    assign error_pulse = (r_state == FAIL);
    assign locked_out  = (r_state == LOCKOUT);
    assign digit_count = r_digit_count;
    assign state_o     = r_state;

endmodule
